// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed integrate-and-fire step scheduler.
// Holds the controller state encoding, default sizing and the two datapath functions.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_IN    = 3;
  localparam int DEF_NUM_OUT   = 3;
  localparam int DEF_W_WIDTH   = 4;
  localparam int DEF_V_WIDTH   = 8;
  localparam int DEF_THRESHOLD = 4;
  localparam int DEF_W_RESET   = 1;

  // Widest fire vector the priority encoder accepts.
  localparam int MAX_OUT = 32;

  // One extra bit of headroom on the sum, then clamp; never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

  // Returns 1 + lowest set index of fire[n-1:0], or 0 when nothing fired.
  function automatic logic [31:0] prio_class(input logic [MAX_OUT-1:0] fire,
                                             input int n);
    logic [31:0] cls;
    cls = '0;
    for (int k = n - 1; k >= 0; k--) begin
      if (fire[k]) cls = 32'(k + 1);
    end
    return cls;
  endfunction

endpackage

// File: rtl/snn_weight_store.sv
// NUM_OUT x NUM_IN synaptic weight registers: one write port, one combinational
// read port addressed by the scheduler's (neuron, input) counters.
module snn_weight_store
  import snn_pkg::*;
#(
  parameter  int NUM_IN  = DEF_NUM_IN,
  parameter  int NUM_OUT = DEF_NUM_OUT,
  parameter  int W_WIDTH = DEF_W_WIDTH,
  parameter  int W_RESET = DEF_W_RESET,
  localparam int NW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int IW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [NW-1:0]      wr_neuron,
  input  logic [IW-1:0]      wr_input,
  input  logic [W_WIDTH-1:0] wdata,
  input  logic [NW-1:0]      rd_neuron,
  input  logic [IW-1:0]      rd_input,
  output logic [W_WIDTH-1:0] rdata
);

  logic [W_WIDTH-1:0] w_q [NUM_OUT][NUM_IN];
  logic               wr_ok;

  // Indices that fall outside the array are dropped rather than aliased.
  assign wr_ok = we && (32'(wr_neuron) < 32'(NUM_OUT))
                    && (32'(wr_input) < 32'(NUM_IN));

  // NOTE: this array is deliberately reset because every weight must come up at a
  // known value; a true RAM macro could not be reset like this.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_OUT; n++) begin
        for (int k = 0; k < NUM_IN; k++) begin
          w_q[n][k] <= W_WIDTH'(W_RESET);
        end
      end
    end else if (wr_ok) begin
      w_q[wr_neuron][wr_input] <= wdata;
    end
  end

  assign rdata = w_q[rd_neuron][rd_input];

endmodule

// File: rtl/snn_if_step_scheduler.sv
// Sequences one shared saturating accumulator over every (neuron, input) pair per
// timestep, then threshold-checks, fires and resets each integrate-and-fire neuron.
module snn_if_step_scheduler
  import snn_pkg::*;
#(
  parameter  int NUM_IN    = DEF_NUM_IN,
  parameter  int NUM_OUT   = DEF_NUM_OUT,
  parameter  int W_WIDTH   = DEF_W_WIDTH,
  parameter  int V_WIDTH   = DEF_V_WIDTH,
  parameter  int THRESHOLD = DEF_THRESHOLD,
  parameter  int W_RESET   = DEF_W_RESET,
  localparam int NW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int IW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int CW        = $clog2(NUM_OUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_IN-1:0]  input_spike,
  input  logic               clear_v,
  input  logic               cfg_we,
  input  logic [NW-1:0]      cfg_neuron,
  input  logic [IW-1:0]      cfg_input,
  input  logic [W_WIDTH-1:0] cfg_wdata,
  output logic               busy,
  output logic               step_done,
  output logic [NUM_OUT-1:0] out_spike,
  output logic [CW-1:0]      out_class
);

  localparam logic [V_WIDTH-1:0] V_MAX = '1;

  state_t              state_q, state_d;
  logic [NW-1:0]       j_q;
  logic [IW-1:0]       i_q;
  logic [NUM_IN-1:0]   spike_q;
  logic [NUM_OUT-1:0]  fire_q;
  logic [V_WIDTH-1:0]  v_q [NUM_OUT];

  logic                last_in, last_out;
  logic                cfg_wr;
  logic [W_WIDTH-1:0]  w_rd;
  logic [V_WIDTH-1:0]  v_cur, v_sum;
  logic                v_ge_th;

  assign last_in  = (i_q == IW'(NUM_IN - 1));
  assign last_out = (j_q == NW'(NUM_OUT - 1));

  // Configuration only lands in IDLE, and loses to start and clear_v.
  assign cfg_wr = (state_q == IDLE) && !start && !clear_v && cfg_we;

  snn_weight_store #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .W_WIDTH (W_WIDTH),
    .W_RESET (W_RESET)
  ) u_weights (
    .clk       (clk),
    .reset     (reset),
    .we        (cfg_wr),
    .wr_neuron (cfg_neuron),
    .wr_input  (cfg_input),
    .wdata     (cfg_wdata),
    .rd_neuron (j_q),
    .rd_input  (i_q),
    .rdata     (w_rd)
  );

  assign v_cur   = v_q[j_q];
  assign v_sum   = V_WIDTH'(sat_add(32'(v_cur), 32'(w_rd), 32'(V_MAX)));
  assign v_ge_th = (32'(v_cur) >= 32'(THRESHOLD));

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_in) state_d = FIRE;
      FIRE:    state_d = last_out ? DONE : ACCUM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    step_done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      j_q     <= '0;
      i_q     <= '0;
      spike_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            spike_q <= input_spike;
            j_q     <= '0;
            i_q     <= '0;
          end
        end
        ACCUM: i_q <= i_q + 1'b1;
        FIRE: begin
          i_q <= '0;
          if (!last_out) j_q <= j_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Membrane potentials: integrate in ACCUM, reset-on-fire in FIRE, bulk clear in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_OUT; n++) v_q[n] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!start && clear_v) begin
            for (int n = 0; n < NUM_OUT; n++) v_q[n] <= '0;
          end
        end
        ACCUM: if (spike_q[i_q]) v_q[j_q] <= v_sum;
        FIRE:  if (v_ge_th) v_q[j_q] <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q    <= '0;
      out_spike <= '0;
      out_class <= '0;
    end else begin
      if (state_q == FIRE) fire_q[j_q] <= v_ge_th;
      if (state_q == DONE) begin
        out_spike <= fire_q;
        out_class <= CW'(prio_class(MAX_OUT'(fire_q), NUM_OUT));
      end
    end
  end

endmodule
